// File: rtl/issue_queue_compact.sv
// Age-ordered collapsing issue queue: oldest-first select of up to ISS_W ready entries, compaction, dispatch append.
// Latency: a ready entry can issue the cycle after dispatch; a wakeup makes a waiting entry issuable next cycle.
// Backpressure: iss_ready=0 holds the selection; disp_ready requires DISP_W free slots and ignores same-cycle frees.
module issue_queue_compact #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int DISP_W = 2,
    parameter int ISS_W  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [DISP_W-1:0]            disp_valid,
    input  logic [DISP_W*DATA_W-1:0]     disp_data,
    input  logic [DISP_W*TAG_W-1:0]      disp_tag,
    input  logic [DISP_W-1:0]            disp_rdy,
    output logic                         disp_ready,
    input  logic                         wake_valid,
    input  logic [TAG_W-1:0]             wake_tag,
    output logic [ISS_W-1:0]             iss_valid,
    output logic [ISS_W*DATA_W-1:0]      iss_data,
    input  logic                         iss_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  rdy_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [CNT_W-1:0]  count_q;

    logic [DEPTH-1:0]  sel;
    logic [DEPTH-1:0]  nxt_valid;
    logic [DEPTH-1:0]  nxt_rdy;
    logic [TAG_W-1:0]  nxt_tag  [DEPTH];
    logic [DATA_W-1:0] nxt_data [DEPTH];
    logic [CNT_W-1:0]  nxt_count;

    assign count      = count_q;
    assign disp_ready = (DEPTH - int'(count_q)) >= DISP_W;

    // Select looks only at registered state, so a wakeup this cycle cannot feed it.
    always_comb begin
        int seen;
        seen      = 0;
        sel       = '0;
        iss_valid = '0;
        iss_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rdy_q[i] && seen < ISS_W) begin
                sel[i] = 1'b1;
                for (int k = 0; k < ISS_W; k++) begin
                    if (k == seen) begin
                        iss_valid[k]                 = 1'b1;
                        iss_data[k*DATA_W +: DATA_W] = data_q[i];
                    end
                end
                seen++;
            end
        end
    end

    // Survivors slide down to slot s in age order; accepted dispatch lanes land behind them.
    always_comb begin
        int s;
        s         = 0;
        nxt_valid = '0;
        nxt_rdy   = '0;
        for (int j = 0; j < DEPTH; j++) begin
            nxt_tag[j]  = '0;
            nxt_data[j] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && !(sel[i] && iss_ready)) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == s) begin
                        nxt_valid[j] = 1'b1;
                        nxt_rdy[j]   = rdy_q[i] | (wake_valid && tag_q[i] == wake_tag);
                        nxt_tag[j]   = tag_q[i];
                        nxt_data[j]  = data_q[i];
                    end
                end
                s++;
            end
        end
        if (disp_ready) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (disp_valid[k]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == s) begin
                            nxt_valid[j] = 1'b1;
                            nxt_rdy[j]   = disp_rdy[k] |
                                           (wake_valid && disp_tag[k*TAG_W +: TAG_W] == wake_tag);
                            nxt_tag[j]   = disp_tag[k*TAG_W +: TAG_W];
                            nxt_data[j]  = disp_data[k*DATA_W +: DATA_W];
                        end
                    end
                    s++;
                end
            end
        end
        nxt_count = CNT_W'(s);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q <= '0;
            rdy_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= nxt_valid;
            rdy_q   <= nxt_rdy;
            tag_q   <= nxt_tag;
            data_q  <= nxt_data;
            count_q <= nxt_count;
        end
    end
endmodule

// File: tb/tb_issue_queue_compact.sv
// Bench for issue_queue_compact: queue-based reference model checked every cycle, plus directed literal checks.
module tb_issue_queue_compact;
    localparam int DEPTH = 8, DATA_W = 32, TAG_W = 6, DISP_W = 2, ISS_W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush;
    logic [1:0]  disp_valid, disp_rdy;
    logic [63:0] disp_data;
    logic [11:0] disp_tag;
    logic        disp_ready, wake_valid, iss_ready;
    logic [5:0]  wake_tag;
    logic [1:0]  iss_valid;
    logic [63:0] iss_data;
    logic [3:0]  count;

    logic        flush_b, disp_valid_b, disp_rdy_b, disp_ready_b, wake_valid_b, iss_ready_b;
    logic [31:0] disp_data_b;
    logic [5:0]  disp_tag_b, wake_tag_b;
    logic [2:0]  iss_valid_b;
    logic [95:0] iss_data_b;
    logic [2:0]  count_b;

    issue_queue_compact #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .DISP_W(DISP_W), .ISS_W(ISS_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .disp_valid(disp_valid), .disp_data(disp_data),
        .disp_tag(disp_tag), .disp_rdy(disp_rdy), .disp_ready(disp_ready), .wake_valid(wake_valid),
        .wake_tag(wake_tag), .iss_valid(iss_valid), .iss_data(iss_data), .iss_ready(iss_ready), .count(count));

    issue_queue_compact #(.DEPTH(4), .DATA_W(32), .TAG_W(6), .DISP_W(1), .ISS_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .disp_valid(disp_valid_b), .disp_data(disp_data_b),
        .disp_tag(disp_tag_b), .disp_rdy(disp_rdy_b), .disp_ready(disp_ready_b), .wake_valid(wake_valid_b),
        .wake_tag(wake_tag_b), .iss_valid(iss_valid_b), .iss_data(iss_data_b), .iss_ready(iss_ready_b),
        .count(count_b));

    typedef struct {
        logic [31:0] data;
        logic [5:0]  tag;
        bit          rdy;
    } ent_t;

    ent_t mq[$];
    int   n_chk = 0, n_fail = 0;
    bit   chk_en = 0;
    logic [1:0]  ev;
    logic [63:0] ed;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected issue lanes: first ISS_W ready entries of the model queue, oldest first.
    task automatic model_sel(output logic [1:0] v, output logic [63:0] d);
        int n;
        n = 0; v = '0; d = '0;
        foreach (mq[i]) begin
            if (mq[i].rdy && n < ISS_W) begin
                v[n] = 1'b1;
                d[n*32 +: 32] = mq[i].data;
                n++;
            end
        end
    endtask

    task automatic model_step();
        ent_t nq[$];
        ent_t e;
        int   n;
        bit   can;
        n   = 0;
        can = (DEPTH - mq.size()) >= DISP_W;
        if (!rst_n || flush) begin
            mq.delete();
            return;
        end
        foreach (mq[i]) begin
            e = mq[i];
            if (e.rdy && n < ISS_W) begin
                n++;
                if (iss_ready) continue;
            end
            if (wake_valid && e.tag == wake_tag) e.rdy = 1'b1;
            nq.push_back(e);
        end
        if (can) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (disp_valid[k]) begin
                    e.data = disp_data[k*32 +: 32];
                    e.tag  = disp_tag[k*6 +: 6];
                    e.rdy  = disp_rdy[k] || (wake_valid && e.tag == wake_tag);
                    nq.push_back(e);
                end
            end
        end
        mq = nq;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            model_sel(ev, ed);
            check("count", count, mq.size());
            check("disp_ready", disp_ready, (DEPTH - mq.size()) >= DISP_W);
            check("iss_valid", iss_valid, ev);
            check("iss_data", iss_data, ed);
            assert (count <= DEPTH) else $error("count overflow %0d", count);
            assert (disp_valid != 2'b10) else $error("non-contiguous disp_valid");
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = '0; disp_data = '0; disp_tag = '0; disp_rdy = '0;
        wake_valid = 1'b0; wake_tag = '0; flush = 1'b0; iss_ready = 1'b1;
    endtask

    task automatic disp(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [5:0] t0, input logic [5:0] t1, input logic [1:0] r);
        disp_valid = v; disp_data = {d1, d0}; disp_tag = {t1, t0}; disp_rdy = r;
    endtask

    task automatic lanes(input string name, input logic [31:0] l0, input logic [31:0] l1);
        check({name, "_valid"}, iss_valid, 2'b11);
        check({name, "_lane0"}, iss_data[31:0], l0);
        check({name, "_lane1"}, iss_data[63:32], l1);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        flush_b = 1'b0; disp_valid_b = 1'b0; disp_rdy_b = 1'b0; disp_data_b = '0; disp_tag_b = '0;
        wake_valid_b = 1'b0; wake_tag_b = '0; iss_ready_b = 1'b0;

        tick();
        chk_en = 1;
        tick();
        check("rst_count", count, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_iss_valid", iss_valid, 0);
        check("rst_count_b", count_b, 0);
        check("rst_disp_ready_b", disp_ready_b, 1);
        rst_n = 1'b1;

        // Fill 1..8; data 3 and 6 wait on tag 10, the rest on tag 11.
        for (int p = 0; p < 4; p++) begin
            disp(2'b11, 32'(2*p+1), 32'(2*p+2), (2*p+1 == 3) ? 6'd10 : 6'd11,
                 (2*p+2 == 6) ? 6'd10 : 6'd11, 2'b00);
            tick();
        end
        idle();
        check("fill_count", count, 8);
        check("fill_disp_ready", disp_ready, 0);
        check("fill_iss_valid", iss_valid, 0);

        wake_valid = 1'b1; wake_tag = 6'd10;
        tick();
        idle();
        lanes("hole_sel", 3, 6);
        tick();
        check("hole_count", count, 6);
        check("hole_iss_valid", iss_valid, 0);
        wake_valid = 1'b1; wake_tag = 6'd11;
        tick();
        idle();
        lanes("order_a", 1, 2);
        tick();
        lanes("order_b", 4, 5);
        check("order_b_count", count, 4);
        tick();
        lanes("order_c", 7, 8);
        tick();
        check("drain_count", count, 0);
        check("drain_iss_valid", iss_valid, 0);

        disp(2'b11, 1, 2, 5, 9, 2'b00);
        tick();
        disp(2'b11, 3, 4, 5, 9, 2'b00);
        tick();
        disp(2'b11, 10, 11, 5, 5, 2'b00);
        wake_valid = 1'b1; wake_tag = 6'd5;
        tick();
        idle();
        check("sim_count", count, 6);
        lanes("sim_sel", 1, 3);
        tick();
        lanes("sim_next", 10, 11);
        check("sim_next_count", count, 4);
        tick();

        disp(2'b11, 20, 21, 7, 7, 2'b11);
        wake_valid = 1'b1; wake_tag = 6'd9; iss_ready = 1'b0;
        tick();
        idle();
        iss_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            lanes("stall", 2, 4);
            check("stall_count", count, 4);
            tick();
        end
        disp(2'b11, 30, 31, 1, 1, 2'b11);
        flush = 1'b1; iss_ready = 1'b1;
        tick();
        idle();
        check("flush_count", count, 0);
        check("flush_iss_valid", iss_valid, 0);

        iss_ready = 1'b0;
        disp(2'b11, 40, 41, 1, 1, 2'b11);  tick();
        disp(2'b11, 42, 43, 2, 2, 2'b00);  tick();
        disp(2'b11, 44, 45, 2, 2, 2'b00);  tick();
        disp(2'b01, 46, 0, 2, 0, 2'b00);   tick();
        idle();
        check("seven_count", count, 7);
        check("seven_disp_ready", disp_ready, 0);
        lanes("seven_sel", 40, 41);
        disp(2'b11, 50, 51, 3, 3, 2'b11);
        tick();
        idle();
        check("nocredit_count", count, 5);
        check("nocredit_iss_valid", iss_valid, 0);

        rst_n = 1'b0; flush = 1'b1;
        tick();
        idle();
        rst_n = 1'b1;
        check("midrst_count", count, 0);

        for (int i = 1; i <= 4; i++) begin
            disp_valid_b = 1'b1; disp_data_b = 32'(i); disp_rdy_b = 1'b1; disp_tag_b = 6'd1;
            tick();
            if (i == 3) begin
                check("b3_count", count_b, 3);
                check("b3_disp_ready", disp_ready_b, 1);
            end
        end
        disp_valid_b = 1'b0;
        check("b4_count", count_b, 4);
        check("b4_disp_ready", disp_ready_b, 0);
        check("b4_iss_valid", iss_valid_b, 3'b111);
        check("b4_iss_data", iss_data_b, {32'd3, 32'd2, 32'd1});
        iss_ready_b = 1'b1;
        tick();
        check("b_after_count", count_b, 1);
        check("b_after_iss_valid", iss_valid_b, 3'b001);
        check("b_after_lane0", iss_data_b[31:0], 4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/issue_queue_compact.md
Name: issue_queue_compact

Overview:
- Parametrised, age-ordered, collapsing issue queue.
- Holds up to DEPTH instructions in oldest-first order (slot 0 = oldest).
- Accepts up to DISP_W dispatches per cycle and tracks one wakeup tag per entry.
- Each cycle it issues up to ISS_W oldest ready entries, then compacts the survivors towards slot 0 and appends new dispatches behind them.
- Sits between rename/dispatch and the execute units.

Parameters:
DEPTH, 8, number of queue entries (>= 2)
DATA_W, 32, instruction payload width
TAG_W, 6, wakeup/source tag width
DISP_W, 2, dispatch lanes per cycle (<= DEPTH)
ISS_W, 2, issue lanes per cycle (<= DEPTH)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  invalidate all entries
disp_valid  in  DISP_W  per-lane dispatch valid; lanes must be contiguous from lane 0
disp_data  in  DISP_W*DATA_W  dispatch payloads, lane k at [k*DATA_W +: DATA_W]
disp_tag  in  DISP_W*TAG_W  source tag each dispatched entry waits on
disp_rdy  in  DISP_W  entry already ready at dispatch
disp_ready  out  1  queue can accept a full DISP_W group this cycle
wake_valid  in  1  wakeup broadcast valid
wake_tag  in  TAG_W  wakeup tag
iss_valid  out  ISS_W  issue lane valid; lane 0 = oldest selected entry
iss_data  out  ISS_W*DATA_W  issued payloads
iss_ready  in  1  downstream accepts all valid issue lanes this cycle
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Entry state: valid, rdy, tag, data. Valid entries always occupy slots 0..count-1, contiguous and oldest-first.
- Reset (rst_n=0 at edge): all valid=0, rdy=0, count=0. Combinationally this gives iss_valid=0 and disp_ready=1.
- Reset mid-operation discards all contents. Its priority is above flush.
- disp_ready = ((DEPTH - count) >= DISP_W). It is combinational from registered count and does not credit same-cycle issues.
- Dispatch is accepted only when disp_ready=1. Lanes with disp_valid=0 are ignored. Non-contiguous disp_valid is illegal; the bench asserts against it.
- Issue select is combinational from registered state:
  - Pick the ISS_W lowest-index slots with valid & rdy.
  - Lane k gets the (k+1)th oldest such slot.
  - Unused lanes have iss_valid=0 and iss_data=0.
  - A wakeup in the current cycle does not affect this cycle's selection.
- Removal: selected entries are removed at the edge only if iss_ready=1. If iss_ready=0, nothing issues, and the same selection is re-presented next cycle unless state changes.
- Next-state, at each edge (flush=0):
  1. Survivors = valid entries not removed, in original relative order.
  2. They are compacted to slots 0..S-1.
  3. Accepted dispatch lanes are appended at slots S, S+1, ... in lane order.
  4. count_next = count - issued + dispatched.
- Wakeup: when wake_valid=1, every surviving entry with tag==wake_tag gets rdy=1 at the edge. A same-cycle dispatched lane gets rdy = disp_rdy | (wake_valid & tag==wake_tag).
- rdy never clears while an entry is valid.
- flush=1: all entries invalid and count=0 next cycle. Same-cycle dispatch and issue removal are ignored. iss_valid still reflects current state that cycle, but downstream must ignore it under flush.
- Full (count=DEPTH): disp_ready=0; issue still proceeds.
- Empty: iss_valid=0.
- Simultaneous issue+dispatch at count=DEPTH-DISP_W+1: disp_ready=0, because freed slots are not credited.
- count never exceeds DEPTH; an overflow is an assertion failure.
- Latency: dispatch→earliest issue = 1 cycle, if disp_rdy=1 or the entry is woken at dispatch. Wakeup→issue of a waiting entry = 1 cycle.

Test Plan:
- Reset then fill: rst_n=0 for 2 cycles → count=0, disp_ready=1, iss_valid=00. Then dispatch pairs with disp_rdy=00 for 4 cycles (data 1..8) → count=8, disp_ready=0, slots hold 1..8 in order.
- Oldest-first issue: fill 1..8, all ready, iss_ready=1 → iss_data lanes show 1,2 then 3,4 then ...; count decrements by 2 each cycle; empty after 4 cycles.
- Compaction hole: 8 entries, only slots 2 and 5 ready (data 3, 6) → issue 3,6. Next cycle slots hold 1,2,4,5,7,8 and count=6.
- Simultaneous issue+dispatch+wakeup: count=4 (data 1-4, tags 5,9,5,9, none ready), wake_tag=5, dispatch data 10,11 with tag 5 → next cycle count=6, slots 1,2,3,4,10,11. rdy set on 1,3,10,11; next issue outputs 1,3.
- Stall and flush: entries ready, iss_ready=0 for 3 cycles → identical iss_data each cycle, count unchanged. Then assert flush together with a dispatch → next cycle count=0, iss_valid=00.
- Parameter sweep: DEPTH=4, DISP_W=1, ISS_W=3 → disp_ready drops at count=4. Three ready entries issue in one cycle.
